// File: rtl/gol_pkg.sv
// gol_pkg: shared types and constants for the Game of Life generation scheduler.
package gol_pkg;

   typedef enum logic [1:0] {
      PAUSED    = 2'd0,
      WAIT_TICK = 2'd1,
      WAIT_VB   = 2'd2,
      STEP      = 2'd3
   } sched_state_t;

   localparam int HEIGHT_DEFAULT    = 20;
   localparam int TICK_BASE_DEFAULT = 1_562_500;

   // Row index width for a board of the given height (border rows included).
   function automatic int row_w(input int height);
      return (height > 2) ? $clog2(height) : 1;
   endfunction

endpackage

// File: rtl/gol_rate_timer.sv
// gol_rate_timer: generation interval counter; tick fires once the count reaches
// (TICK_BASE << speed) - 1, or immediately if a speed change put the limit below the count.
module gol_rate_timer #(
   parameter int TICK_BASE = 4,
   parameter int SPEED_W   = 3,
   parameter int CNT_W     = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               en,
   input  logic [SPEED_W-1:0] speed,
   output logic               tick
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] limit;

   always_comb begin
      limit = (CNT_W'(TICK_BASE) << speed) - CNT_W'(1);
      tick  = en && (cnt_q >= limit);
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (en && !tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gol_scheduler.sv
// gol_scheduler: sequences row loads and run/step/clear control, launching generations only in vblank.
// Defining GOL_GEN_LIMIT_EN auto-pauses after MAX_GENS generations until the next clear.
module gol_scheduler
   import gol_pkg::*;
#(
   parameter int HEIGHT    = HEIGHT_DEFAULT,
   parameter int TICK_BASE = TICK_BASE_DEFAULT,
   parameter int SPEED_W   = 3,
   parameter int GEN_W     = 16,
   parameter int MAX_GENS  = 1000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      load_pulse,
   input  logic                      run_pulse,
   input  logic                      step_pulse,
   input  logic                      clear_pulse,
   input  logic [SPEED_W-1:0]        speed,
   input  logic                      vblank,
   input  logic                      step_done,
   output logic                      step_req,
   output logic                      clear_req,
   output logic                      load_we,
   output logic [row_w(HEIGHT)-1:0]  load_row,
   output logic                      running,
   output logic [GEN_W-1:0]          gen_count
);

   localparam int ROW_W = row_w(HEIGHT);
   localparam int CNT_W = $clog2(TICK_BASE) + 2 ** SPEED_W;
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 2);
   localparam logic [GEN_W-1:0] GEN_LIMIT = GEN_W'(MAX_GENS);

`ifdef GOL_GEN_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   sched_state_t     state_q, state_d;
   logic             running_q, running_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic [ROW_W-1:0] ptr_q, ptr_d;
   logic             clear_req_q, clear_req_d;
   logic             pending_q, pending_d;
   logic             lock_q, lock_d;
   logic             vb_meta_q, vb_s_q;

   logic             do_clear;
   logic             load_ok;
   logic [GEN_W-1:0] gen_inc;
   logic             limit_hit;
   logic             tick;
   logic             timer_start;
   logic             timer_en;

   gol_rate_timer #(
      .TICK_BASE (TICK_BASE),
      .SPEED_W   (SPEED_W),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (reset_n),
      .start (timer_start),
      .en    (timer_en),
      .speed (speed),
      .tick  (tick)
   );

   assign gen_inc   = gen_q + GEN_W'(1);
   assign limit_hit = LIMIT_EN && (gen_inc == GEN_LIMIT);

   // State register, including the vblank synchronizer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= PAUSED;
         running_q   <= 1'b0;
         gen_q       <= '0;
         ptr_q       <= ROW_FIRST;
         clear_req_q <= 1'b0;
         pending_q   <= 1'b0;
         lock_q      <= 1'b0;
         vb_meta_q   <= 1'b0;
         vb_s_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         running_q   <= running_d;
         gen_q       <= gen_d;
         ptr_q       <= ptr_d;
         clear_req_q <= clear_req_d;
         pending_q   <= pending_d;
         lock_q      <= lock_d;
         vb_meta_q   <= vblank;
         vb_s_q      <= vb_meta_q;
      end
   end

   // Next-state logic. Pulse priority is clear > run > step > load.
   always_comb begin
      state_d   = state_q;
      running_d = running_q;
      gen_d     = gen_q;
      ptr_d     = ptr_q;
      pending_d = pending_q;
      lock_d    = lock_q;
      do_clear  = 1'b0;
      load_ok   = 1'b0;
      case (state_q)
         PAUSED: begin
            if (clear_pulse) begin
               do_clear = 1'b1;
            end else if (run_pulse && !lock_q) begin
               running_d = 1'b1;
               state_d   = WAIT_TICK;
            end else if (step_pulse) begin
               state_d = WAIT_VB;
            end else if (load_pulse) begin
               load_ok = 1'b1;
            end
         end
         WAIT_TICK: begin
            if (clear_pulse) begin
               do_clear = 1'b1;
            end else if (run_pulse) begin
               running_d = 1'b0;
               state_d   = PAUSED;
            end else if (tick) begin
               state_d = WAIT_VB;
            end
         end
         WAIT_VB: begin
            if (clear_pulse) begin
               do_clear = 1'b1;
            end else if (run_pulse) begin
               running_d = 1'b0;
               state_d   = PAUSED;
            end else if (vb_s_q) begin
               state_d = STEP;
            end
         end
         STEP: begin
            // The engine handshake always completes; clear and mode changes wait for it.
            if (clear_pulse) begin
               pending_d = 1'b1;
            end
            if (run_pulse && !lock_q) begin
               running_d = !running_q;
            end
            if (step_done) begin
               gen_d = gen_inc;
               if (clear_pulse || pending_q) begin
                  do_clear = 1'b1;
               end else if (limit_hit) begin
                  running_d = 1'b0;
                  lock_d    = 1'b1;
                  state_d   = PAUSED;
               end else begin
                  state_d = running_d ? WAIT_TICK : PAUSED;
               end
            end
         end
         default: state_d = PAUSED;
      endcase
      if (do_clear) begin
         state_d   = PAUSED;
         running_d = 1'b0;
         gen_d     = '0;
         ptr_d     = ROW_FIRST;
         pending_d = 1'b0;
         lock_d    = 1'b0;
      end
      if (load_ok) begin
         ptr_d = (ptr_q == ROW_LAST) ? ROW_FIRST : ptr_q + ROW_W'(1);
      end
      clear_req_d = do_clear;
   end

   // Outputs.
   always_comb begin
      step_req    = (state_q == STEP);
      clear_req   = clear_req_q;
      load_we     = load_ok;
      load_row    = ptr_q;
      running     = running_q;
      gen_count   = gen_q;
      timer_en    = (state_q == WAIT_TICK);
      timer_start = (state_d == WAIT_TICK) && (state_q != WAIT_TICK);
   end

endmodule

// File: doc/gol_scheduler.md
Name: gol_scheduler

Overview:
- Generation scheduler between the debounced button pulses and the game engine.
- Sequences row-by-row board loading from the switches, and run/pause/single-step/clear control.
- Paces generations with a programmable-rate timer and launches each generation only during VGA vertical blank, so the display never tears.
- Talks to the engine over a req/done handshake.

Parameters:
- HEIGHT, 20: board rows including the zero border; loadable rows are 1..HEIGHT-2.
- TICK_BASE, 1_562_500: clk cycles per generation at speed 0.
- SPEED_W, 3: width of the speed select.
- GEN_W, 16: generation counter width.
- MAX_GENS, 1000: auto-pause limit, used only with GOL_GEN_LIMIT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- load_pulse  in  1  one-cycle pulse: load switches into the current row.
- run_pulse  in  1  one-cycle pulse: toggle run/pause.
- step_pulse  in  1  one-cycle pulse: single generation while paused.
- clear_pulse  in  1  one-cycle pulse: clear board, counters and row pointer.
- speed  in  SPEED_W  generation interval = TICK_BASE << speed cycles.
- vblank  in  1  VGA vertical blank level (vga_clk domain).
- step_done  in  1  one-cycle pulse from engine: generation written.
- step_req  out  1  level request to compute one generation.
- clear_req  out  1  one-cycle board clear strobe.
- load_we  out  1  one-cycle row write strobe.
- load_row  out  $clog2(HEIGHT)  destination row for load_we.
- running  out  1  high while in free-run mode.
- gen_count  out  GEN_W  generations completed since clear.

Behaviour:
- Reset values: state PAUSED; step_req=0, clear_req=0, load_we=0, running=0, gen_count=0, load_row=1, tick counter=0, clear_pending=0.
- vblank passes through a 2-flop synchronizer; vb_s is the synchronized value. vblank-to-launch latency is 2..3 cycles.
- States:
  - PAUSED: idle.
    - run_pulse -> WAIT_TICK, running=1.
    - step_pulse -> WAIT_VB with single=1.
    - load_pulse -> load_we=1 for 1 cycle with load_row=ptr; then ptr increments; after HEIGHT-2 it wraps to 1.
  - WAIT_TICK: counter counts up from 0. At TICK_BASE<<speed - 1 -> WAIT_VB.
    - speed change takes effect at the next comparison; if the counter already exceeds the new limit, go to WAIT_VB immediately.
  - WAIT_VB: when vb_s=1 -> STEP.
  - STEP: step_req=1 and held until the cycle step_done=1 is sampled.
    - On that cycle: gen_count+1 (wraps at 2^GEN_W), step_req drops the next cycle.
    - Next state: WAIT_TICK if running, else PAUSED.
  - step_done outside STEP is ignored.
- run_pulse in WAIT_TICK/WAIT_VB: running=0 -> PAUSED, no step issued.
- run_pulse in STEP: running toggles; the handshake completes, then the new mode applies.
- Priority on simultaneous pulses: clear > run > step > load.
- load_pulse and step_pulse are ignored outside PAUSED.
- Clear outside STEP: clear_req one cycle, gen_count=0, load_row=1, running=0, -> PAUSED.
- Clear in STEP: sets clear_pending. The clear executes in the cycle after step_done; gen_count ends at 0, not +1.
- The tick counter resets on every entry to WAIT_TICK. Ticks are never queued; a slow engine simply lowers the generation rate.

Optional Feature:
- Macro: GOL_GEN_LIMIT_EN.
- Defined: when gen_count reaches MAX_GENS on a step_done, running is forced to 0 and the next state is PAUSED. Further run_pulse is ignored until clear; step_pulse is still honoured.
- Undefined: no limit; gen_count wraps freely. MAX_GENS is unused.

Decomposition:
- Package gol_pkg:
  - typedef enum sched_state_t {PAUSED, WAIT_TICK, WAIT_VB, STEP};
  - row index width localparam derived from HEIGHT;
  - default TICK_BASE constant.
- One sub-module: gol_rate_timer, the loadable tick counter with the shifted-limit compare. It takes speed and a start strobe and gives a tick pulse. The synchronizer is inline.

Test Plan:
- Reset → step_req 0, load_row=1, running=0, gen_count=0. Seven load_pulses with HEIGHT=8 → load_we rows 1,2,3,4,5,6,1.
- TICK_BASE=4, speed=1, run_pulse, vblank held 1, engine acks 2 cycles after req → step_req rises every 8 counter cycles plus handshake; gen_count 1,2,3.
- Running, vblank held 0 for 100 cycles then pulsed high → no step_req until 2 cycles after vblank rises. Exactly one step per vblank window.
- clear_pulse during STEP with step_done 3 cycles later → clear_req the cycle after step_done, gen_count=0, running=0, state PAUSED.
- clear_pulse and run_pulse in the same cycle while PAUSED → clear only; running stays 0. step_pulse while running → ignored.
- GOL_GEN_LIMIT_EN, MAX_GENS=3 → after the third step_done running=0 and run_pulse is ignored. After clear_pulse, run_pulse resumes.
